id_char_feeder: RTL and testbench
=================================

// Module: id_char_feeder
// PURPOSE
//  Upstream stage of the ID checker. Accepts one ID string as ASCII bytes over a valid/ready stream.
//  Buffers the full frame and checks its format. Maps each char to the checker's 6-bit symbol code
//  (digits 0-9, letters 10-35), then replays the frame as one gap-free ID_LEN-cycle in_valid/in_id burst.
//  Guarantees idle cycles between bursts so the checker's counter re-arms.
// PARAMETERS
//  ID_LEN   10  symbols per ID frame (checker expects 10)
//  GAP_CYC  2   min cycles out_valid held low after a burst before the next frame is accepted (>=1)
// PORTS
//  clk         in   1  rising-edge clock
//  rst_n       in   1  asynchronous active-low reset
//  ascii_valid in   1  byte present on ascii_data
//  ascii_data  in   8  ASCII character
//  ascii_last  in   1  marks final byte of a frame; qualified by ascii_valid
//  ascii_ready out  1  feeder can take a byte this cycle
//  out_valid   out  1  drives checker in_valid
//  out_id      out  6  drives checker in_id; symbol code
//  fmt_err     out  1  one-cycle pulse: frame rejected, no burst emitted
//  err_code    out  2  valid with fmt_err: 1 = illegal char/position, 2 = length mismatch
//  busy        out  1  high in any state other than COLLECT with zero chars held
// BEHAVIOUR
//  - Clock and reset: single clock clk; reset rst_n is asynchronous, active-low. Reset is asynchronous
//    and may occur anywhere, including mid-burst. On reset:
//    - FSM goes to COLLECT and the char index is cleared.
//    - Outputs: ascii_ready=1, out_valid=0, out_id=0, fmt_err=0, err_code=0, busy=0.
//  - Handshake: a byte transfers when ascii_valid && ascii_ready. ascii_ready=1 only in COLLECT and DROP.
//  - Symbol mapping (stored per position, 6 bits):
//    - '0'-'9' map to 0-9.
//    - Letters follow the national table: A10 B11 C12 D13 E14 F15 G16 H17 I34 J18 K19 L20 M21
//      N22 O35 P23 Q24 R25 S26 T27 U28 V29 W32 X30 Y31 Z33.
//  - Format rules, checked per byte at accept:
//    - pos0 must be a letter.
//    - pos1 must be '1' or '2'.
//    - pos2..ID_LEN-1 must be a digit.
//  - FSM states:
//    - COLLECT: store symbol at index idx, then idx++.
//      - Illegal char: if ascii_last, pulse fmt_err code1 and go to COLLECT with idx=0. Else go to DROP
//        and latch code1.
//      - ascii_last with idx+1<ID_LEN: pulse fmt_err code2, idx=0.
//      - idx+1==ID_LEN without ascii_last: go to DROP and latch code2.
//      - idx+1==ID_LEN with ascii_last and all legal: go to SEND.
//    - DROP: accept and discard bytes until ascii_last. On that transfer, pulse fmt_err with the latched
//      code, then go to COLLECT with idx=0.
//    - SEND: out_valid=1 for exactly ID_LEN consecutive cycles. out_id = buf[k], k=0..ID_LEN-1.
//      Starts the cycle after the last-byte transfer. Then go to GAP.
//    - GAP: out_valid=0 and out_id=0 for GAP_CYC cycles, then go to COLLECT.
//  - Latency: last byte accepted at cycle T; first out_valid at T+1; last at T+ID_LEN.
//  - fmt_err is registered and is asserted the cycle after the offending terminating transfer.
//  - Only one error per frame is reported: the first one detected.
//  - out_id is 0 whenever out_valid=0. Counters wrap only through explicit clears, never modulo.
//  - ascii_valid with ascii_ready=0 is ignored. Upstream must hold the byte.
// CONFIGURATION
//  LOWERCASE_EN defined:
//    - 'a'-'z' are accepted wherever letters are legal and map to the same codes as uppercase.
//  LOWERCASE_EN undefined:
//    - Lowercase letters are illegal chars (fmt_err code1).
// TESTING
//  1. Bytes "A123456789", last on '9' -> out_valid 10 cycles, out_id 10,1,2,3,4,5,6,7,8,9; fmt_err never.
//  2. "I2........" with digits -> first out_id=34. Back-to-back frame: ascii_ready low for 10+GAP_CYC cycles.
//  3. "A323456789" -> fmt_err=1 with err_code=1 the cycle after '9'; out_valid stays 0.
//  4. 9 bytes "A12345678" with last -> fmt_err code2. Then 11 bytes, last on 11th -> DROP, fmt_err code2 after 11th.
//  5. rst_n low at 4th SEND cycle -> out_valid=0 immediately; next valid frame emits a full clean burst.
//  6. "a123456789": LOWERCASE_EN -> burst starts out_id=10. Without it -> fmt_err code1.

Source files
------------

// File: rtl/id_char_feeder.sv
// Buffers one ASCII ID frame, validates its format, maps chars to 6-bit symbol codes and replays
// the frame as a gap-free ID_LEN-cycle burst. Define LOWERCASE_EN to accept 'a'-'z' as letters.
//
// state     | meaning
// COLLECT   | accepting and storing frame bytes at idx
// DROP      | discarding bytes of a rejected frame until ascii_last
// SEND      | replaying stored symbols, out_valid high
// GAP       | idle cycles after a burst so the checker re-arms
module id_char_feeder #(
  parameter int ID_LEN  = 10,
  parameter int GAP_CYC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ascii_valid,
  input  logic [7:0] ascii_data,
  input  logic       ascii_last,
  output logic       ascii_ready,
  output logic       out_valid,
  output logic [5:0] out_id,
  output logic       fmt_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int IW = $clog2(ID_LEN + 1);
  localparam int GW = $clog2(GAP_CYC + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(ID_LEN - 1);
  localparam logic [IW-1:0] LEN_IDX  = IW'(ID_LEN);

  typedef enum logic [1:0] {S_COLLECT, S_DROP, S_SEND, S_GAP} state_t;

  state_t         state;
  logic [IW-1:0]  idx;
  logic [GW-1:0]  gap_cnt;
  logic [1:0]     err_lat;
  logic [5:0]     sym_buf [ID_LEN];

  logic [7:0]     ch_up;
  logic           is_digit;
  logic           is_letter;
  logic           pos_ok;
  logic [5:0]     sym;
  logic           take;

  // National letter table: I and O are pushed to the end, W sits out of order.
  function automatic logic [5:0] letter_code(input logic [7:0] c);
    logic [5:0] code;
    case (c)
      "A": code = 6'd10;  "B": code = 6'd11;  "C": code = 6'd12;  "D": code = 6'd13;
      "E": code = 6'd14;  "F": code = 6'd15;  "G": code = 6'd16;  "H": code = 6'd17;
      "I": code = 6'd34;  "J": code = 6'd18;  "K": code = 6'd19;  "L": code = 6'd20;
      "M": code = 6'd21;  "N": code = 6'd22;  "O": code = 6'd35;  "P": code = 6'd23;
      "Q": code = 6'd24;  "R": code = 6'd25;  "S": code = 6'd26;  "T": code = 6'd27;
      "U": code = 6'd28;  "V": code = 6'd29;  "W": code = 6'd32;  "X": code = 6'd30;
      "Y": code = 6'd31;  "Z": code = 6'd33;
      default: code = 6'd0;
    endcase
    return code;
  endfunction

  always_comb begin
    ch_up = ascii_data;
`ifdef LOWERCASE_EN
    if (ascii_data >= 8'h61 && ascii_data <= 8'h7a) ch_up = ascii_data - 8'h20;
`endif
    is_digit  = (ascii_data >= 8'h30) && (ascii_data <= 8'h39);
    is_letter = (ch_up >= 8'h41) && (ch_up <= 8'h5a);
    sym       = is_digit ? {2'b00, ascii_data[3:0]} : letter_code(ch_up);
    if (idx == '0)
      pos_ok = is_letter;
    else if (idx == IW'(1))
      pos_ok = (ascii_data == 8'h31) || (ascii_data == 8'h32);
    else
      pos_ok = is_digit;
  end

  assign take = ascii_valid && ascii_ready;
  assign busy = !(state == S_COLLECT && idx == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_COLLECT;
      idx         <= '0;
      gap_cnt     <= '0;
      err_lat     <= 2'd0;
      ascii_ready <= 1'b1;
      out_valid   <= 1'b0;
      out_id      <= 6'd0;
      fmt_err     <= 1'b0;
      err_code    <= 2'd0;
      for (int i = 0; i < ID_LEN; i++) sym_buf[i] <= 6'd0;
    end else begin
      fmt_err  <= 1'b0;
      err_code <= 2'd0;
      case (state)
        S_COLLECT: begin
          if (take) begin
            sym_buf[idx] <= sym;
            if (!pos_ok) begin
              idx <= '0;
              if (ascii_last) begin
                fmt_err  <= 1'b1;
                err_code <= 2'd1;
              end else begin
                state   <= S_DROP;
                err_lat <= 2'd1;
              end
            end else if (idx != LAST_IDX) begin
              if (ascii_last) begin
                fmt_err  <= 1'b1;
                err_code <= 2'd2;
                idx      <= '0;
              end else begin
                idx <= idx + 1'b1;
              end
            end else if (!ascii_last) begin
              state   <= S_DROP;
              err_lat <= 2'd2;
              idx     <= '0;
            end else begin
              // The final symbol is written this edge, so buf[0] is already stable.
              state       <= S_SEND;
              ascii_ready <= 1'b0;
              out_valid   <= 1'b1;
              out_id      <= (ID_LEN == 1) ? sym : sym_buf[0];
              idx         <= IW'(1);
            end
          end
        end
        S_DROP: begin
          if (take && ascii_last) begin
            fmt_err  <= 1'b1;
            err_code <= err_lat;
            state    <= S_COLLECT;
            idx      <= '0;
          end
        end
        S_SEND: begin
          if (idx == LEN_IDX) begin
            out_valid <= 1'b0;
            out_id    <= 6'd0;
            state     <= S_GAP;
            gap_cnt   <= GW'(GAP_CYC - 1);
            idx       <= '0;
          end else begin
            out_id <= sym_buf[idx];
            idx    <= idx + 1'b1;
          end
        end
        S_GAP: begin
          if (gap_cnt == '0) begin
            state       <= S_COLLECT;
            ascii_ready <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= S_COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_id_char_feeder.sv
// Scoreboard bench for id_char_feeder: a reference model queues expected symbols and error codes
// per frame; a monitor pops and compares them as the DUT produces bursts and fmt_err pulses.
module tb_id_char_feeder;

  localparam int ID_LEN  = 10;
  localparam int GAP_CYC = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ascii_valid = 1'b0;
  logic [7:0] ascii_data = 8'h00;
  logic       ascii_last = 1'b0;
  logic       ascii_ready;
  logic       out_valid;
  logic [5:0] out_id;
  logic       fmt_err;
  logic [1:0] err_code;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_id_q[$];
  int exp_err_q[$];
  int letter_tab[26] = '{10, 11, 12, 13, 14, 15, 16, 17, 34, 18, 19, 20, 21,
                         22, 35, 23, 24, 25, 26, 27, 28, 29, 32, 30, 31, 33};

  id_char_feeder #(.ID_LEN(ID_LEN), .GAP_CYC(GAP_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .ascii_valid(ascii_valid), .ascii_data(ascii_data),
    .ascii_last(ascii_last), .ascii_ready(ascii_ready), .out_valid(out_valid),
    .out_id(out_id), .fmt_err(fmt_err), .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_frame(input string s);
    int   err;
    int   code;
    int   codes[$];
    byte  c;
    bit   last, up, lo, dig, letter, ok;
    err = 0;
    for (int i = 0; i < s.len(); i++) begin
      c    = s[i];
      last = (i == s.len() - 1);
      up   = (c >= "A" && c <= "Z");
      lo   = (c >= "a" && c <= "z");
      dig  = (c >= "0" && c <= "9");
`ifdef LOWERCASE_EN
      letter = up || lo;
`else
      letter = up;
`endif
      if (i == 0)      ok = letter;
      else if (i == 1) ok = (c == "1") || (c == "2");
      else             ok = dig;
      code = dig ? int'(c - "0") : up ? letter_tab[c - "A"] : lo ? letter_tab[c - "a"] : 0;
      if (!ok) begin err = 1; break; end
      codes.push_back(code);
      if (last && i < ID_LEN - 1) begin err = 2; break; end
      if (!last && i == ID_LEN - 1) begin err = 2; break; end
    end
    if (err != 0) exp_err_q.push_back(err);
    else foreach (codes[k]) exp_id_q.push_back(codes[k]);
  endtask

  // Returns on the falling edge of the cycle after the last-byte transfer.
  task automatic send_frame(input string s);
    int tmo;
    model_frame(s);
    for (int i = 0; i < s.len(); i++) begin
      ascii_data  = s[i];
      ascii_last  = (i == s.len() - 1);
      ascii_valid = 1'b1;
      tmo = 0;
      while (!ascii_ready && tmo < 200) begin
        @(negedge clk);
        tmo++;
      end
      chk("ready_before_xfer", ascii_ready, 1);
      @(negedge clk);
      if (i == 0 && s.len() > 1) chk("busy_mid_frame", busy, 1);
      ascii_valid = 1'b0;
      ascii_last  = 1'b0;
      if (i != s.len() - 1 && $urandom_range(3) == 0) begin
        ascii_data = 8'h71;
        @(negedge clk);
      end
    end
  endtask

  task automatic ready_low_span(input string tag, input int expected);
    int cnt;
    cnt = 0;
    while (!ascii_ready && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    chk(tag, cnt, expected);
  endtask

  task automatic monitor();
    int run;
    run = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        run = 0;
        exp_id_q.delete();
        exp_err_q.delete();
      end else begin
        if (out_valid) begin
          run++;
          if (exp_id_q.size() == 0) chk("unexpected_valid", out_valid, 0);
          else chk("out_id", out_id, exp_id_q.pop_front());
        end else begin
          if (run != 0) chk("burst_len", run, ID_LEN);
          run = 0;
          chk("idle_out_id", out_id, 0);
        end
        if (fmt_err) begin
          if (exp_err_q.size() == 0) chk("unexpected_fmt_err", fmt_err, 0);
          else chk("err_code", err_code, exp_err_q.pop_front());
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string good[$];
    fork monitor(); join_none

    repeat (3) @(negedge clk);
    chk("rst_ascii_ready", ascii_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_id", out_id, 0);
    chk("rst_fmt_err", fmt_err, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    send_frame("A123456789");
    chk("t1_first_valid", out_valid, 1);
    chk("t1_first_id", out_id, 10);
    ready_low_span("t1_ready_low", ID_LEN + GAP_CYC);

    send_frame("I298765432");
    chk("t2_first_id", out_id, 34);
    ready_low_span("t2_ready_low", ID_LEN + GAP_CYC);
    send_frame("B112345678");
    chk("t2b_first_valid", out_valid, 1);
    ready_low_span("t2b_ready_low", ID_LEN + GAP_CYC);

    send_frame("A323456789");
    chk("t3_fmt_err", fmt_err, 1);
    chk("t3_out_valid", out_valid, 0);
    chk("t3_ready", ascii_ready, 1);
    @(negedge clk);
    chk("t3_err_pulse_width", fmt_err, 0);

    send_frame("A12345678");
    chk("t4a_fmt_err", fmt_err, 1);
    send_frame("A1234567890");
    chk("t4b_fmt_err", fmt_err, 1);
    send_frame("A12X");
    chk("t4c_fmt_err", fmt_err, 1);
    send_frame("A12345678901X");
    chk("t4d_fmt_err", fmt_err, 1);
    send_frame("7");
    chk("t4e_fmt_err", fmt_err, 1);

    good = '{"Z100000000", "O299999999", "W154321098"};
    foreach (good[g]) begin
      send_frame(good[g]);
      chk("good_first_valid", out_valid, 1);
      ready_low_span("good_ready_low", ID_LEN + GAP_CYC);
    end

    send_frame("C123456789");
    repeat (3) @(negedge clk);
    chk("t5_valid_before_rst", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_out_valid", out_valid, 0);
    chk("t5_async_out_id", out_id, 0);
    chk("t5_async_ready", ascii_ready, 1);
    repeat (2) @(negedge clk);
    chk("t5_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame("D223456789");
    chk("t5_clean_valid", out_valid, 1);
    chk("t5_clean_first_id", out_id, 13);
    ready_low_span("t5_ready_low", ID_LEN + GAP_CYC);

    send_frame("a123456789");
`ifdef LOWERCASE_EN
    chk("t6_lower_valid", out_valid, 1);
    chk("t6_lower_first_id", out_id, 10);
    ready_low_span("t6_ready_low", ID_LEN + GAP_CYC);
`else
    chk("t6_lower_fmt_err", fmt_err, 1);
    chk("t6_lower_no_valid", out_valid, 0);
`endif

    repeat (5) @(negedge clk);
    chk("pending_ids", exp_id_q.size(), 0);
    chk("pending_errs", exp_err_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
